// File: rtl/sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_drive_arbiter
// Purpose  : Round-robin arbiter from per-drive sector requests to hps_io SD.
// Revision : 1.0
// ============================================================================
module sd_drive_arbiter #(
    parameter int DRIVES  = 2,
    parameter int SECT_AW = 9,
    parameter int TIMEOUT = 16000000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [DRIVES-1:0]    img_mounted,
    input  logic [63:0]          img_size,
    input  logic [DRIVES-1:0]    req_rd,
    input  logic [DRIVES-1:0]    req_wr,
    input  logic [32*DRIVES-1:0] req_lba,
    output logic [DRIVES-1:0]    req_busy,
    output logic [DRIVES-1:0]    req_done,
    output logic [DRIVES-1:0]    req_err,
    output logic [DRIVES-1:0]    mounted,
    output logic [31:0]          sd_lba,
    output logic [DRIVES-1:0]    sd_rd,
    output logic [DRIVES-1:0]    sd_wr,
    input  logic                 sd_ack,
    input  logic [SECT_AW-1:0]   sd_buff_addr,
    input  logic [7:0]           sd_buff_dout,
    input  logic                 sd_buff_wr,
    output logic [7:0]           sd_buff_din,
    input  logic [SECT_AW-1:0]   buf_addr,
    input  logic [7:0]           buf_din,
    input  logic                 buf_we,
    output logic [7:0]           buf_dout
);

    localparam int c_idx_w = (DRIVES > 1) ? $clog2(DRIVES) : 1;
    localparam int c_tmr_w = $clog2(TIMEOUT + 1);
    localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(DRIVES - 1);
    localparam logic [c_tmr_w-1:0] c_timeout  = c_tmr_w'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [DRIVES-1:0]    r_pend, r_pwr;
    logic [31:0]          r_plba [DRIVES];
    logic [c_idx_w-1:0]   r_last, r_sel, w_rr_sel;
    logic [DRIVES-1:0]    w_sel_onehot;
    logic                 w_any_pend;
    logic                 r_err, r_lost;
    logic [c_tmr_w-1:0]   r_timer, w_timer_inc;
    logic                 w_timeout;
    logic                 w_core_we;
    logic [7:0]           r_mem [2**SECT_AW];

    assign req_busy     = r_pend;
    assign w_any_pend   = |r_pend;
    assign w_sel_onehot = DRIVES'(1) << w_rr_sel;
    assign w_timer_inc  = r_timer + c_tmr_w'(1);
    assign w_timeout    = (w_timer_inc == c_timeout);
    assign w_core_we    = buf_we && (r_state == ST_IDLE);

    // First pending drive strictly after the last one served, wrapping.
    always_comb begin : p_rr
        int idx;
        idx      = 0;
        w_rr_sel = r_last;
        for (int k = DRIVES; k >= 1; k--) begin
            idx = int'(r_last) + k;
            if (idx >= DRIVES) idx = idx - DRIVES;
            if (r_pend[idx[c_idx_w-1:0]]) w_rr_sel = idx[c_idx_w-1:0];
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_pend) w_state_nxt = mounted[w_rr_sel] ? ST_REQ : ST_DONE;
            ST_REQ: begin
                if (sd_ack)         w_state_nxt = ST_XFER;
                else if (w_timeout) w_state_nxt = ST_DONE;
            end
            ST_XFER: if (!sd_ack) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_pend   <= '0;
            r_pwr    <= '0;
            for (int i = 0; i < DRIVES; i++) r_plba[i] <= '0;
            r_last   <= c_last_rst;
            r_sel    <= '0;
            r_err    <= 1'b0;
            r_lost   <= 1'b0;
            r_timer  <= '0;
            sd_lba   <= '0;
            sd_rd    <= '0;
            sd_wr    <= '0;
            req_done <= '0;
            req_err  <= '0;
            mounted  <= '0;
        end else begin
            req_done <= '0;
            // A write arriving together with a read takes precedence.
            for (int i = 0; i < DRIVES; i++) begin
                if (img_mounted[i]) mounted[i] <= (img_size != 64'd0);
                if (!r_pend[i] && (req_rd[i] || req_wr[i])) begin
                    r_pend[i]  <= 1'b1;
                    r_pwr[i]   <= req_wr[i];
                    r_plba[i]  <= req_lba[32*i +: 32];
                    req_err[i] <= 1'b0;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_any_pend) begin
                        r_sel   <= w_rr_sel;
                        sd_lba  <= r_plba[w_rr_sel];
                        r_lost  <= 1'b0;
                        r_timer <= '0;
                        if (mounted[w_rr_sel]) begin
                            if (r_pwr[w_rr_sel]) sd_wr <= w_sel_onehot;
                            else                 sd_rd <= w_sel_onehot;
                            r_err <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (!mounted[r_sel]) r_lost <= 1'b1;
                    if (sd_ack) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                    end else if (w_timeout) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                ST_XFER: begin
                    if (!mounted[r_sel]) r_lost <= 1'b1;
                    if (!sd_ack) r_err <= r_lost | ~mounted[r_sel];
                end
                ST_DONE: begin
                    req_done[r_sel] <= 1'b1;
                    req_err[r_sel]  <= r_err;
                    r_pend[r_sel]   <= 1'b0;
                    r_last          <= r_sel;
                end
                default: ;
            endcase
        end
    end

    // Shared sector buffer; reads return pre-write data on address collision.
    always_ff @(posedge clk_sys) begin
        if (w_core_we)  r_mem[buf_addr]     <= buf_din;
        if (sd_buff_wr) r_mem[sd_buff_addr] <= sd_buff_dout;
        sd_buff_din <= r_mem[sd_buff_addr];
        buf_dout    <= r_mem[buf_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_drive_arbiter
// Purpose  : Directed and randomized checks of sd_drive_arbiter.
// Revision : 1.0
// ============================================================================
module tb_sd_drive_arbiter;

    localparam int ND = 2;
    localparam int AW = 9;
    localparam int TO = 100;

    logic            clk_sys = 1'b0;
    logic            reset = 1'b1;
    logic [ND-1:0]   img_mounted = '0;
    logic [63:0]     img_size = '0;
    logic [ND-1:0]   req_rd = '0, req_wr = '0;
    logic [32*ND-1:0] req_lba = '0;
    logic [ND-1:0]   req_busy, req_done, req_err, mounted, sd_rd, sd_wr;
    logic [31:0]     sd_lba;
    logic            sd_ack = 1'b0;
    logic [AW-1:0]   sd_buff_addr = '0, buf_addr = '0;
    logic [7:0]      sd_buff_dout = '0, buf_din = '0;
    logic            sd_buff_wr = 1'b0, buf_we = 1'b0;
    logic [7:0]      sd_buff_din, buf_dout;

    sd_drive_arbiter #(.DRIVES(ND), .SECT_AW(AW), .TIMEOUT(TO)) dut (
        .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
        .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_busy(req_busy),
        .req_done(req_done), .req_err(req_err), .mounted(mounted), .sd_lba(sd_lba),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we), .buf_dout(buf_dout)
    );

    always #5 clk_sys = ~clk_sys;

    int         total = 0;
    int         bad = 0;
    bit         m_mounted [ND];
    bit         m_err [ND];
    int         m_last = ND - 1;
    logic [7:0] m_mem [2**AW];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic mount(input int d, input logic [63:0] sz);
        img_mounted    = '0;
        img_mounted[d] = 1'b1;
        img_size       = sz;
        cyc(1);
        img_mounted    = '0;
        img_size       = '0;
        m_mounted[d]   = (sz != 0);
    endtask

    task automatic issue(input logic [ND-1:0] rd, input logic [ND-1:0] wr, input logic [32*ND-1:0] lba);
        req_rd  = rd;
        req_wr  = wr;
        req_lba = lba;
        cyc(1);
        req_rd  = '0;
        req_wr  = '0;
        for (int d = 0; d < ND; d++) if (rd[d] | wr[d]) m_err[d] = 1'b0;
    endtask

    // Plays the hps_io side of one transfer and checks the completion.
    task automatic serve(input int d, input bit wr, input logic [31:0] lba, input bit drop);
        int n;
        n = 0;
        while ((sd_rd | sd_wr) == '0 && n < 50) begin
            cyc(1);
            n++;
        end
        chk("sd_req_seen", 64'(n < 50), 64'd1);
        chk("sd_rd", 64'(sd_rd), wr ? 64'd0 : 64'(1 << d));
        chk("sd_wr", 64'(sd_wr), wr ? 64'(1 << d) : 64'd0);
        chk("sd_lba", 64'(sd_lba), 64'(lba));
        cyc($urandom_range(0, 3));
        chk("sd_hold", 64'(sd_rd | sd_wr), 64'(1 << d));
        sd_ack = 1'b1;
        cyc(1);
        if (drop) begin
            img_mounted    = '0;
            img_mounted[d] = 1'b1;
            img_size       = '0;
        end
        cyc(1);
        img_mounted = '0;
        if (drop) m_mounted[d] = 1'b0;
        chk("sd_release", 64'(sd_rd | sd_wr), 64'd0);
        cyc($urandom_range(0, 3));
        sd_ack = 1'b0;
        cyc(1);
        chk("done_not_early", 64'(req_done), 64'd0);
        cyc(1);
        chk("done_pulse", 64'(req_done), 64'(1 << d));
        chk("done_err", 64'(req_err[d]), 64'(drop));
        chk("busy_fall", 64'(req_busy[d]), 64'd0);
        m_err[d] = drop;
        m_last   = d;
        cyc(1);
    endtask

    task automatic await_unmounted(input int d);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (req_done == '0 && n < 20) begin
            if ((sd_rd | sd_wr) != '0) seen = 1'b1;
            cyc(1);
            n++;
        end
        chk("unm_done", 64'(req_done), 64'(1 << d));
        chk("unm_err", 64'(req_err[d]), 64'd1);
        chk("unm_no_sd", 64'(seen), 64'd0);
        m_err[d] = 1'b1;
        m_last   = d;
        cyc(1);
    endtask

    function automatic logic [ND-1:0] err_vec();
        logic [ND-1:0] v;
        for (int d = 0; d < ND; d++) v[d] = m_err[d];
        return v;
    endfunction

    initial begin
        int cnt;
        logic [ND-1:0]    rd, wr, mask;
        logic [32*ND-1:0] lba;
        int               order [$];

        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("rst_sd_rd", 64'(sd_rd), 64'd0);
        chk("rst_sd_wr", 64'(sd_wr), 64'd0);
        chk("rst_sd_lba", 64'(sd_lba), 64'd0);
        chk("rst_busy", 64'(req_busy), 64'd0);
        chk("rst_done", 64'(req_done), 64'd0);
        chk("rst_err", 64'(req_err), 64'd0);
        chk("rst_mounted", 64'(mounted), 64'd0);

        // Mount, read LBA 0x12, fill the buffer from the hps_io side.
        mount(0, 64'd737280);
        chk("mount0", 64'(mounted), 64'd1);
        issue(2'b01, 2'b00, {32'd0, 32'h12});
        chk("t1_busy", 64'(req_busy), 64'd1);
        chk("t1_sd_not_yet", 64'(sd_rd), 64'd0);
        cyc(1);
        chk("t1_sd_rd", 64'(sd_rd), 64'd1);
        chk("t1_sd_lba", 64'(sd_lba), 64'h12);
        sd_ack = 1'b1;
        cyc(1);
        for (int i = 0; i < 2**AW; i++) begin
            sd_buff_addr = AW'(i);
            sd_buff_dout = 8'(i) ^ 8'h5A;
            m_mem[i]     = 8'(i) ^ 8'h5A;
            sd_buff_wr   = 1'b1;
            cyc(1);
        end
        sd_buff_wr = 1'b0;
        chk("t1_sd_rd_low", 64'(sd_rd), 64'd0);
        sd_ack = 1'b0;
        cyc(1);
        chk("t1_done_early", 64'(req_done), 64'd0);
        cyc(1);
        chk("t1_done", 64'(req_done), 64'd1);
        chk("t1_err", 64'(req_err), 64'd0);
        chk("t1_busy_fall", 64'(req_busy), 64'd0);
        m_last = 0;
        cyc(1);
        chk("t1_done_once", 64'(req_done), 64'd0);
        for (int i = 0; i < 2**AW; i++) begin
            buf_addr = AW'(i);
            cyc(1);
            chk("t1_buf_rd", 64'(buf_dout), 64'(m_mem[i]));
        end

        // Core-side write while idle, then a same-address collision.
        buf_addr = AW'(8); buf_din = 8'h99; buf_we = 1'b1;
        cyc(1);
        buf_we = 1'b0; m_mem[8] = 8'h99;
        sd_buff_addr = AW'(8);
        cyc(1);
        chk("core_wr_sd_din", 64'(sd_buff_din), 64'h99);
        sd_buff_addr = AW'(9); sd_buff_dout = 8'h11; sd_buff_wr = 1'b1; buf_addr = AW'(9);
        cyc(1);
        sd_buff_wr = 1'b0;
        chk("collide_old", 64'(buf_dout), 64'(m_mem[9]));
        m_mem[9] = 8'h11;
        cyc(1);
        chk("collide_new", 64'(buf_dout), 64'h11);

        // Round-robin from last=1, core write blocked while busy.
        mount(1, 64'd1234);
        issue(2'b10, 2'b00, {32'h0000_0042, 32'd0});
        serve(1, 1'b0, 32'h42, 1'b0);
        issue(2'b01, 2'b10, {32'hBEEF_0001, 32'h0000_0077});
        cyc(1);
        buf_addr = AW'(7); buf_din = 8'hC3; buf_we = 1'b1;
        cyc(1);
        buf_we = 1'b0;
        serve(0, 1'b0, 32'h77, 1'b0);
        chk("t2_d1_still_busy", 64'(req_busy), 64'b10);
        serve(1, 1'b1, 32'hBEEF_0001, 1'b0);
        buf_addr = AW'(7);
        cyc(1);
        chk("core_we_blocked", 64'(buf_dout), 64'(m_mem[7]));

        // Unmounted drive completes with error and no sd request.
        mount(1, 64'd0);
        issue(2'b10, 2'b00, {32'h5, 32'd0});
        chk("t3_busy", 64'(req_busy), 64'b10);
        cyc(1);
        chk("t3_done_early", 64'(req_done), 64'd0);
        chk("t3_no_sd_1", 64'(sd_rd | sd_wr), 64'd0);
        cyc(1);
        chk("t3_done", 64'(req_done), 64'b10);
        chk("t3_err", 64'(req_err), 64'b10);
        chk("t3_no_sd_2", 64'(sd_rd | sd_wr), 64'd0);
        m_err[1] = 1'b1; m_last = 1;
        cyc(1);

        // Timeout with no acknowledge.
        issue(2'b01, 2'b00, {32'd0, 32'h55});
        cyc(1);
        cnt = 0;
        while (sd_rd != '0 && cnt < 3*TO) begin
            cnt++;
            cyc(1);
        end
        chk("t4_req_cycles", 64'(cnt), 64'(TO));
        cyc(1);
        chk("t4_done", 64'(req_done), 64'b01);
        chk("t4_err", 64'(req_err), 64'b11);
        m_err[0] = 1'b1; m_last = 0;
        cyc(1);
        issue(2'b01, 2'b00, {32'd0, 32'h56});
        serve(0, 1'b0, 32'h56, 1'b0);
        chk("t4_recover_err", 64'(req_err), 64'(err_vec()));

        // Reset during the data phase.
        issue(2'b01, 2'b00, {32'd0, 32'h99});
        cyc(1);
        sd_ack = 1'b1;
        cyc(2);
        reset = 1'b1;
        #1;
        chk("t5_sd_rd", 64'(sd_rd), 64'd0);
        chk("t5_busy", 64'(req_busy), 64'd0);
        chk("t5_mounted", 64'(mounted), 64'd0);
        cyc(1);
        reset = 1'b0; sd_ack = 1'b0;
        for (int d = 0; d < ND; d++) begin m_mounted[d] = 1'b0; m_err[d] = 1'b0; end
        m_last = ND - 1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (req_done != '0) cnt++;
            cyc(1);
        end
        chk("t5_no_done", 64'(cnt), 64'd0);
        mount(0, 64'd512);
        issue(2'b01, 2'b00, {32'd0, 32'h1});
        cyc(1);
        chk("t5_idle_after_rst", 64'(sd_rd), 64'b01);
        serve(0, 1'b0, 32'h1, 1'b0);

        // Read+write together: write wins, request while busy ignored.
        issue(2'b01, 2'b01, {32'd0, 32'hAAA});
        chk("t6_busy", 64'(req_busy), 64'b01);
        req_rd = 2'b01; req_lba = {32'd0, 32'hBBB};
        cyc(1);
        req_rd = '0;
        serve(0, 1'b1, 32'hAAA, 1'b0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if ((sd_rd | sd_wr | req_done) != '0) cnt++;
            cyc(1);
        end
        chk("t6_single_done", 64'(cnt), 64'd0);

        // Randomized batches against a round-robin service-order model.
        for (int b = 0; b < 40; b++) begin
            for (int d = 0; d < ND; d++)
                if ($urandom_range(0, 3) == 0)
                    mount(d, ($urandom_range(0, 2) == 0) ? 64'd0 : 64'(1 + $urandom));
            mask = ND'($urandom_range(1, 2**ND - 1));
            rd = '0; wr = '0; lba = '0;
            for (int d = 0; d < ND; d++) begin
                if (mask[d]) begin
                    int op;
                    op = $urandom_range(1, 3);
                    rd[d] = op[0];
                    wr[d] = op[1];
                    lba[32*d +: 32] = $urandom;
                end
            end
            order.delete();
            for (int k = 1; k <= ND; k++) begin
                int d;
                d = (m_last + k) % ND;
                if (mask[d]) order.push_back(d);
            end
            issue(rd, wr, lba);
            chk("rnd_busy", 64'(req_busy), 64'(mask));
            if ($urandom_range(0, 1) == 1) begin
                req_rd  = mask;
                req_wr  = mask & ND'($urandom);
                req_lba = {$urandom, $urandom};
                cyc(1);
                req_rd  = '0;
                req_wr  = '0;
            end
            foreach (order[j]) begin
                int d;
                d = order[j];
                if (m_mounted[d]) serve(d, wr[d], lba[32*d +: 32], $urandom_range(0, 7) == 0);
                else              await_unmounted(d);
            end
            chk("rnd_err_vec", 64'(req_err), 64'(err_vec()));
            chk("rnd_idle", 64'(req_busy), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
